// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounced single-shot key events
// Drives one active-low column at a time and samples the synchronised rows on each scan tick.
module keypad_scan #(
   parameter int CLK_HZ         = 50000000,
   parameter int SCAN_HZ        = 400,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_down
);

   localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
   localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [3:0]        MATCH_N   = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   logic [3:0]        row_meta_q;
   logic [3:0]        rs_q;
   logic [TICK_W-1:0] tick_cnt_q;
   logic [TICK_W-1:0] tick_cnt_d;
   logic              tick;

   state_t            state_q;
   logic [1:0]        col_idx_q;
   logic [1:0]        cand_col_q;
   logic [1:0]        cand_row_q;
   logic [3:0]        match_q;
   logic [3:0]        match_d;
   logic              key_valid_q;
   logic [3:0]        key_code_q;
   logic              key_down_q;

   logic              rs_single;
   logic [1:0]        rs_idx;
   logic [3:0]        cand_pat;

   // Rows are asynchronous to CLK; only the second flop is ever looked at.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         row_meta_q <= 4'hF;
         rs_q       <= 4'hF;
      end else begin
         row_meta_q <= row;
         rs_q       <= row_meta_q;
      end
   end

   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // Anything but exactly one low row (idle or ghosting) reads as "no key".
   always_comb begin
      rs_single = 1'b0;
      rs_idx    = 2'd0;
      case (rs_q)
         4'b1110: begin rs_single = 1'b1; rs_idx = 2'd0; end
         4'b1101: begin rs_single = 1'b1; rs_idx = 2'd1; end
         4'b1011: begin rs_single = 1'b1; rs_idx = 2'd2; end
         4'b0111: begin rs_single = 1'b1; rs_idx = 2'd3; end
         default: begin rs_single = 1'b0; rs_idx = 2'd0; end
      endcase
      cand_pat = ~(4'b0001 << cand_row_q);
      match_d  = match_q + 4'd1;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q     <= IDLE;
         col_idx_q   <= 2'd0;
         cand_col_q  <= 2'd0;
         cand_row_q  <= 2'd0;
         match_q     <= 4'd0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
         key_down_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (tick) begin
            case (state_q)
               IDLE: begin
                  if (rs_single) begin
                     cand_col_q <= col_idx_q;
                     cand_row_q <= rs_idx;
                     match_q    <= 4'd0;
                     state_q    <= DEBOUNCE;
                  end else begin
                     col_idx_q <= col_idx_q + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (rs_q == cand_pat) begin
                     if (match_d == MATCH_N) begin
                        key_code_q  <= {cand_col_q, cand_row_q};
                        key_valid_q <= 1'b1;
                        key_down_q  <= 1'b1;
                        match_q     <= 4'd0;
                        state_q     <= HELD;
                     end else begin
                        match_q <= match_d;
                     end
                  end else begin
                     state_q   <= IDLE;
                     col_idx_q <= col_idx_q + 2'd1;
                  end
               end
               HELD: begin
                  // Any low row restarts the release count, so a second key cannot sneak in.
                  if (rs_q == 4'hF) begin
                     if (match_d == MATCH_N) begin
                        key_down_q <= 1'b0;
                        match_q    <= 4'd0;
                        state_q    <= IDLE;
                        col_idx_q  <= cand_col_q + 2'd1;
                     end else begin
                        match_q <= match_d;
                     end
                  end else begin
                     match_q <= 4'd0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  match_q <= 4'd0;
               end
            endcase
         end
      end
   end

   assign col       = ~(4'b0001 << col_idx_q);
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan against a tick-level keypad model
// A virtual keypad answers the driven column; the model predicts outputs from the pressed-key set.
module tb_keypad_scan;

   localparam int N     = 4;
   localparam int TICKC = 8;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_down;
   logic [15:0] keys;

   int errors = 0;
   int checks = 0;

   int m_mode;
   int m_col;
   int m_cnt;
   int m_ccol;
   int m_crow;
   int m_code;
   bit m_down;
   bit m_pulse;

   always #5 CLK = ~CLK;

   keypad_scan #(
      .CLK_HZ(3200),
      .SCAN_HZ(400),
      .DEBOUNCE_SCANS(N)
   ) dut (
      .CLK(CLK),
      .RST_n(RST_n),
      .row(row),
      .col(col),
      .key_valid(key_valid),
      .key_code(key_code),
      .key_down(key_down)
   );

   // Pressed key (c,r) is bit c*4+r of keys; it pulls row r low while column c is driven.
   always_comb begin
      row = 4'hF;
      case (col)
         4'b1110: row = ~keys[3:0];
         4'b1101: row = ~keys[7:4];
         4'b1011: row = ~keys[11:8];
         4'b0111: row = ~keys[15:12];
         default: row = 4'hF;
      endcase
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_col = 0; m_cnt = 0; m_ccol = 0; m_crow = 0;
      m_code = 0; m_down = 0; m_pulse = 0;
   endtask

   // mode 0 = scanning, 1 = confirming a press, 2 = waiting for release
   task automatic model_tick();
      logic [3:0] seen;
      int zeros;
      int zi;
      seen  = ~keys[m_col*4 +: 4];
      zeros = 0;
      zi    = 0;
      for (int r = 0; r < 4; r++) begin
         if (!seen[r]) begin
            zeros++;
            zi = r;
         end
      end
      m_pulse = 0;
      if (m_mode == 0) begin
         if (zeros == 1) begin
            m_ccol = m_col; m_crow = zi; m_cnt = 0; m_mode = 1;
         end else begin
            m_col = (m_col + 1) % 4;
         end
      end else if (m_mode == 1) begin
         if (zeros == 1 && zi == m_crow) begin
            m_cnt++;
            if (m_cnt == N) begin
               m_code = m_ccol * 4 + m_crow;
               m_pulse = 1; m_down = 1; m_mode = 2; m_cnt = 0;
            end
         end else begin
            m_mode = 0;
            m_col = (m_col + 1) % 4;
         end
      end else begin
         if (zeros == 0) begin
            m_cnt++;
            if (m_cnt == N) begin
               m_down = 0; m_mode = 0; m_cnt = 0;
               m_col = (m_ccol + 1) % 4;
            end
         end else begin
            m_cnt = 0;
         end
      end
   endtask

   task automatic tick_step();
      logic [3:0] ecol;
      repeat (TICKC - 1) begin
         @(posedge CLK); #1;
         chk("no_stray_valid", 16'(key_valid), 16'd0);
      end
      @(posedge CLK); #1;
      model_tick();
      ecol = 4'hF;
      ecol[m_col] = 1'b0;
      chk("key_valid", 16'(key_valid), 16'(m_pulse));
      chk("col", 16'(col), 16'(ecol));
      chk("key_down", 16'(key_down), 16'(m_down));
      chk("key_code", 16'(key_code), 16'(m_code));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_col"}, 16'(col), 16'h000E);
      chk({tag, "_valid"}, 16'(key_valid), 16'd0);
      chk({tag, "_down"}, 16'(key_down), 16'd0);
      chk({tag, "_code"}, 16'(key_code), 16'd0);
   endtask

   initial begin
      int guard;
      int r;
      RST_n = 1'b0;
      keys  = 16'h0000;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      @(negedge CLK) RST_n = 1'b1;

      repeat (6) tick_step();

      keys = 16'h0200;
      repeat (10) tick_step();

      keys = 16'h0000;
      repeat (3) tick_step();
      keys = 16'h0200;
      tick_step();
      keys = 16'h0000;
      repeat (6) tick_step();

      keys = 16'h0030;
      repeat (8) tick_step();
      keys = 16'h0000;
      tick_step();

      keys = 16'h0001;
      repeat (8) tick_step();
      keys = 16'h8001;
      repeat (6) tick_step();
      keys = 16'h8000;
      repeat (6) tick_step();
      keys = 16'h0000;
      repeat (6) tick_step();

      for (int i = 0; i < 8; i++) begin
         keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
         tick_step();
      end
      keys = 16'h0001;
      repeat (10) tick_step();
      keys = 16'h0000;
      repeat (6) tick_step();

      keys  = 16'h0004;
      guard = 0;
      while (!(m_mode == 1 && m_cnt == 2) && guard < 20) begin
         tick_step();
         guard++;
      end
      chk("reach_debounce_2", 16'(guard < 20), 16'd1);
      RST_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      repeat (3) begin
         @(posedge CLK); #1;
         chk("valid_in_reset", 16'(key_valid), 16'd0);
      end
      @(negedge CLK) RST_n = 1'b1;
      repeat (8) tick_step();
      keys = 16'h0000;
      repeat (6) tick_step();

      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 3);
            case (r)
               0: keys = 16'h0000;
               1: keys = 16'h0001 << $urandom_range(0, 15);
               2: keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
               default: keys = (keys == 16'h0000) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            endcase
         end
         tick_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
